// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply engine.
// SA_SIGNED_EN selects two's-complement arithmetic in the PEs (default: unsigned).
package sa_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} sa_state_e;

   function automatic int unsigned acc_width(int unsigned dw, int unsigned k_max);
      return 2 * dw + $clog2(k_max);
   endfunction

   // Extra cycles after the last beat for data to reach PE (ROWS-1, COLS-1).
   function automatic int unsigned flush_cycles(int unsigned rows, int unsigned cols);
      return rows + cols - 2;
   endfunction

endpackage

// File: rtl/sa_pe_acc.sv
// One output-stationary PE: multiply-accumulate with pass-through operand registers.
// SA_SIGNED_EN defined: signed operands, product sign-extended into the accumulator.
module sa_pe_acc #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [ACC_WIDTH-1:0] prod_ext;

`ifdef SA_SIGNED_EN
   logic signed [2*DATA_WIDTH-1:0] prod;
   assign prod     = $signed(a_in) * $signed(b_in);
   assign prod_ext = ACC_WIDTH'(prod);
`else
   logic [2*DATA_WIDTH-1:0] prod;
   assign prod     = a_in * b_in;
   assign prod_ext = ACC_WIDTH'(prod);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else if (clr) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else if (en) begin
         acc   <= acc + prod_ext;
         a_out <= a_in;
         b_out <= b_in;
      end
   end

endmodule

// File: rtl/systolic_mm_engine.sv
// ROWS x COLS output-stationary systolic matmul with input skew, K-length FSM and row drain.
// SA_SIGNED_EN (see sa_pe_acc) switches operands and results to two's complement.
module systolic_mm_engine
   import sa_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ROWS       = 8,
   parameter int unsigned COLS       = 8,
   parameter int unsigned K_MAX      = 64,
   parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, K_MAX)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(K_MAX+1)-1:0]    k_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]    a_col,
   input  logic [COLS*DATA_WIDTH-1:0]    b_row,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [COLS*ACC_WIDTH-1:0]     out_row,
   output logic [$clog2(ROWS)-1:0]       out_row_idx,
   output logic                          out_last,
   output logic                          busy
);

   localparam int unsigned KW           = $clog2(K_MAX + 1);
   localparam int unsigned RW           = $clog2(ROWS);
   localparam int unsigned FLUSH_CYCLES = flush_cycles(ROWS, COLS);
   localparam int unsigned FW           = $clog2(FLUSH_CYCLES + 1);

   sa_state_e      state_q, state_d;
   logic [KW-1:0]  k_q, beat_q;
   logic [FW-1:0]  flush_q;
   logic [RW-1:0]  row_q;
   logic           clr, beat, adv, row_hs;

   assign clr    = (state_q == StIdle) && start;
   assign beat   = (state_q == StLoad) && in_valid;
   assign adv    = beat || (state_q == StFlush);
   assign row_hs = (state_q == StDrain) && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = (k_len == '0) ? StFlush : StLoad;
         StLoad:  if (beat && (beat_q == k_q - 1'b1)) state_d = StFlush;
         // One cycle beyond the last product so first out_valid lands ROWS+COLS-1 after.
         StFlush: if (flush_q == FW'(FLUSH_CYCLES)) state_d = StDrain;
         StDrain: if (row_hs && (row_q == RW'(ROWS - 1))) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready    = (state_q == StLoad);
      out_valid   = (state_q == StDrain);
      busy        = (state_q != StIdle);
      out_last    = (state_q == StDrain) && (row_q == RW'(ROWS - 1));
      out_row_idx = row_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q     <= '0;
         beat_q  <= '0;
         flush_q <= '0;
         row_q   <= '0;
      end else begin
         if (clr) begin
            k_q    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
            beat_q <= '0;
         end else if (beat) begin
            beat_q <= beat_q + 1'b1;
         end
         flush_q <= (state_q == StFlush) ? flush_q + 1'b1 : '0;
         if (state_q != StDrain) row_q <= '0;
         else if (row_hs)        row_q <= row_q + 1'b1;
      end
   end

   logic [DATA_WIDTH-1:0] a_skw [ROWS];
   logic [DATA_WIDTH-1:0] b_skw [COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      logic [DATA_WIDTH-1:0] a_src;
      assign a_src = (state_q == StLoad) ? a_col[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (r == 0) begin : g_pass
         assign a_skw[r] = a_src;
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr [r];
         always_ff @(posedge clk or posedge rst) begin
            if (rst || clr) begin
               for (int i = 0; i < r; i++) sr[i] <= '0;
            end else if (adv) begin
               sr[0] <= a_src;
               for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
            end
         end
         assign a_skw[r] = sr[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      logic [DATA_WIDTH-1:0] b_src;
      assign b_src = (state_q == StLoad) ? b_row[c*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (c == 0) begin : g_pass
         assign b_skw[c] = b_src;
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr [c];
         always_ff @(posedge clk or posedge rst) begin
            if (rst || clr) begin
               for (int i = 0; i < c; i++) sr[i] <= '0;
            end else if (adv) begin
               sr[0] <= b_src;
               for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
            end
         end
         assign b_skw[c] = sr[c-1];
      end
   end

   logic [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
   logic [DATA_WIDTH-1:0] b_v [ROWS+1][COLS];
   logic [ACC_WIDTH-1:0]  acc [ROWS][COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign a_h[r][0] = a_skw[r];
      for (genvar c = 0; c < COLS; c++) begin : g_col
         if (r == 0) begin : g_top
            assign b_v[0][c] = b_skw[c];
         end
         sa_pe_acc #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
         ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .clr   (clr),
            .a_in  (a_h[r][c]),
            .b_in  (b_v[r][c]),
            .a_out (a_h[r][c+1]),
            .b_out (b_v[r+1][c]),
            .acc   (acc[r][c])
         );
      end
   end

   always_comb begin
      out_row = '0;
      if (state_q == StDrain) begin
         for (int c = 0; c < COLS; c++) out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][c];
      end
   end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine (8x8, DATA_WIDTH 8, K_MAX 64).
// A matrix-level model computes expected C; one negedge process checks every drained row.
module tb_systolic_mm_engine;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int AW = 22;

   logic              clk, rst, start, in_valid, in_ready;
   logic [6:0]        k_len;
   logic [N*DW-1:0]   a_col, b_row;
   logic              out_valid, out_ready, out_last, busy;
   logic [N*AW-1:0]   out_row;
   logic [2:0]        out_row_idx;

   systolic_mm_engine dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .k_len       (k_len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_col       (a_col),
      .b_row       (b_row),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_last    (out_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int          total, bad;
   bit [7:0]    ma [N][64];
   bit [7:0]    mb [64][N];
   longint      exp_c [N][N];
   longint      got_c [N][N];
   int          exp_idx;
   bit          expect_drain;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic longint ev(input bit [7:0] x);
`ifdef SA_SIGNED_EN
      return longint'($signed(x));
`else
      return longint'(x);
`endif
   endfunction

   task automatic compute_model(input int k);
      longint s;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int i = 0; i < k; i++) s += ev(ma[r][i]) * ev(mb[i][c]);
            exp_c[r][c] = s & ((64'd1 << AW) - 1);
         end
   endtask

   // Row checker: runs every cycle; while stalled the same expected row must stay on the bus.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!expect_drain || exp_idx >= N) begin
            chk("spurious_out_valid", 1, 0);
         end else begin
            chk($sformatf("out_row_idx[%0d]", exp_idx), longint'(out_row_idx), exp_idx);
            chk($sformatf("out_last[%0d]", exp_idx), longint'(out_last), (exp_idx == N - 1));
            for (int c = 0; c < N; c++) begin
               got_c[exp_idx][c] = longint'(out_row[c*AW +: AW]);
               chk($sformatf("C[%0d][%0d]", exp_idx, c), got_c[exp_idx][c], exp_c[exp_idx][c]);
            end
            if (out_ready) exp_idx++;
         end
      end
   end

   task automatic run_job(input int k, input bit gaps, input bit bp, input bit start_noise);
      int  ke, i, n, guard;
      bit  took;
      ke = (k > 64) ? 64 : k;
      compute_model(ke);
      exp_idx = 0;
      start = 1'b1;
      k_len = 7'(k);
      @(posedge clk); #1;
      start = 1'b0;
      k_len = '0;
      i = 0;
      guard = 0;
      while (i < ke && guard < 1000) begin
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         for (int r = 0; r < N; r++) a_col[r*DW +: DW] = ma[r][i];
         for (int c = 0; c < N; c++) b_row[c*DW +: DW] = mb[i][c];
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) i++;
         guard++;
      end
      if (i < ke) chk("beat_timeout", i, ke);
      chk("in_ready_after_load", longint'(in_ready), 0);
      // Garbage offered outside LOAD must be ignored.
      in_valid = 1'b1;
      a_col = {$urandom, $urandom};
      b_row = {$urandom, $urandom};
      expect_drain = 1'b1;
      if (start_noise) begin
         start = 1'b1;
         k_len = 7'd5;
      end
      n = 0;
      while (!out_valid && n < 100) begin
         out_ready = $urandom_range(0, 1);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("first_out_latency", n, 15);
      guard = 0;
      while (exp_idx < N && guard < 500) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         guard++;
      end
      if (exp_idx < N) chk("drain_timeout", exp_idx, N);
      chk("busy_after_drain", longint'(busy), 0);
      expect_drain = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, longint'(in_ready), 0);
      chk({tag, "_out_valid"}, longint'(out_valid), 0);
      chk({tag, "_out_last"}, longint'(out_last), 0);
      chk({tag, "_busy"}, longint'(busy), 0);
      chk({tag, "_out_row_nz"}, longint'(|out_row), 0);
      chk({tag, "_out_row_idx"}, longint'(out_row_idx), 0);
   endtask

   task automatic fill(input int av, input int bv);
      for (int r = 0; r < N; r++)
         for (int i = 0; i < 64; i++) begin
            ma[r][i] = 8'(av);
            mb[i][r] = 8'(bv);
         end
   endtask

   task automatic fill_identity;
      for (int r = 0; r < N; r++)
         for (int i = 0; i < 64; i++) ma[r][i] = (r == i) ? 8'd1 : 8'd0;
      for (int i = 0; i < 64; i++)
         for (int c = 0; c < N; c++) mb[i][c] = 8'((8 * i + c) & 8'hFF);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
      a_col = '0; b_row = '0; out_ready = 1'b0;
      total = 0; bad = 0; exp_idx = 0; expect_drain = 1'b0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Identity: row r = 8r..8r+7
      fill_identity();
      run_job(8, 1'b0, 1'b0, 1'b0);
      chk("lit_identity_C35", got_c[3][5], 29);
      chk("lit_identity_C70", got_c[7][0], 56);

      // All-max operands, full K
      fill(255, 255);
      run_job(64, 1'b0, 1'b0, 1'b0);
      chk("lit_max_C00", got_c[0][0], 4161600);
      chk("lit_max_C77", got_c[7][7], 4161600);

      // Identity with input gaps, output backpressure and ignored start while busy
      fill_identity();
      run_job(8, 1'b1, 1'b1, 1'b1);
      chk("lit_bp_C26", got_c[2][6], 22);

      // k_len = 0: all-zero result
      fill(7, 9);
      run_job(0, 1'b0, 1'b0, 1'b0);
      chk("lit_k0_C44", got_c[4][4], 0);

      // k_len = 100 clamps to 64 beats
      fill(1, 1);
      run_job(100, 1'b0, 1'b1, 1'b0);
      chk("lit_clamp_C51", got_c[5][1], 64);

      // Abort mid-LOAD after three beats
      fill(9, 9);
      start = 1'b1;
      k_len = 7'd8;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_col = {N{8'd9}};
         b_row = {N{8'd9}};
         @(posedge clk); #1;
      end
      chk("midload_busy_before_rst", longint'(busy), 1);
      rst = 1'b1;
      #2;
      check_reset_outputs("abort");
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      fill(2, 3);
      run_job(1, 1'b0, 1'b0, 1'b0);
      chk("lit_after_abort_C66", got_c[6][6], 6);

`ifdef SA_SIGNED_EN
      fill(255, 2);
      run_job(3, 1'b0, 1'b0, 1'b0);
      chk("lit_signed_C24", got_c[2][4], 64'h3FFFFA);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
